// File: rtl/branch_hist_index_if.sv
// Bundle between the fetch-side predictor logic and branch_hist_index.
//   Prediction side: pc_valid, pc, pred_taken in; line, full, empty out.
//   Resolution side: res_valid, res_taken in; upd_valid, upd_line,
//                    upd_taken, mispredict out.
// slave  : branch_hist_index view.
// master : upstream/downstream driver view.
interface branch_hist_index_if #(
  parameter int unsigned ADDR_W = 7
);
  logic              pc_valid;
  logic [ADDR_W-1:0] pc;
  logic              pred_taken;
  logic [ADDR_W-1:0] line;
  logic              res_valid;
  logic              res_taken;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_line;
  logic              upd_taken;
  logic              mispredict;
  logic              full;
  logic              empty;

  modport slave (
    input  pc_valid, pc, pred_taken, res_valid, res_taken,
    output line, upd_valid, upd_line, upd_taken, mispredict, full, empty
  );

  modport master (
    output pc_valid, pc, pred_taken, res_valid, res_taken,
    input  line, upd_valid, upd_line, upd_taken, mispredict, full, empty
  );
endinterface

// File: rtl/branch_hist_index.sv
// Speculative gshare index generator with an in-order resolution queue.
// Hashes each branch pc with the speculative global history to form the
// prediction-table line, remembers in-flight predictions, and on resolve
// emits a registered table update; a mispredict flushes the queue and
// repairs the history from the resolving branch's snapshot.
// Ports:
//   clk   : system clock, rising edge.
//   reset : asynchronous, active-high.
//   bus   : branch_hist_index_if.slave (prediction and resolution signals).
module branch_hist_index #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned HIST_W = 7,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                clk,
  input  logic                reset,
  branch_hist_index_if.slave  bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] line;
    logic [HIST_W-1:0] snap;
    logic              pred;
  } entry_t;

  entry_t            q [DEPTH];
  logic [HIST_W-1:0] ghr;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic   accept;
  logic   resolve;
  logic   mis;
  entry_t head_e;

  // Table index: zero-latency hash of pc with current speculative history.
  assign bus.line  = bus.pc ^ ADDR_W'(ghr);
  assign bus.full  = (count == CNT_W'(DEPTH));
  assign bus.empty = (count == CNT_W'(0));

  // full/empty come from the registered count, so a same-cycle pop never
  // frees a slot for the same-cycle push.
  assign accept  = bus.pc_valid && !bus.full;
  assign resolve = bus.res_valid && !bus.empty;
  assign head_e  = q[head];
  assign mis     = resolve && (bus.res_taken != head_e.pred);

  // Queue, history and pointer state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr   <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) q[i] <= '0;
    end else if (mis) begin
      // Flush wins over any same-cycle accept, including its history shift.
      ghr   <= {head_e.snap[HIST_W-2:0], bus.res_taken};
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (accept) begin
        q[tail] <= '{line: bus.line, snap: ghr, pred: bus.pred_taken};
        tail    <= tail + PTR_W'(1);
        ghr     <= {ghr[HIST_W-2:0], bus.pred_taken};
      end
      if (resolve) head <= head + PTR_W'(1);
      count <= count + CNT_W'(accept) - CNT_W'(resolve);
    end
  end

  // Registered table-update and mispredict outputs, one cycle after resolve.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.upd_valid  <= 1'b0;
      bus.upd_line   <= '0;
      bus.upd_taken  <= 1'b0;
      bus.mispredict <= 1'b0;
    end else begin
      bus.upd_valid  <= resolve;
      bus.mispredict <= mis;
      if (resolve) begin
        bus.upd_line  <= head_e.line;
        bus.upd_taken <= bus.res_taken;
      end
    end
  end

endmodule

// File: tb/tb_branch_hist_index.sv
// Scoreboard bench for branch_hist_index: directed stimulus pushes the
// expected update for every resolve; a monitor compares on upd_valid.
module tb_branch_hist_index;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_hist_index_if #(.ADDR_W(7)) bus ();

  branch_hist_index #(.ADDR_W(7), .HIST_W(7), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [6:0] line;
    logic       taken;
    logic       mis;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  // Monitor: compare every update pulse against the scoreboard.
  always @(negedge clk) begin
    if (bus.upd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL upd_unexpected: got upd_valid=1 expected no update at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("upd_line",   32'(bus.upd_line),   32'(e.line));
        chk("upd_taken",  32'(bus.upd_taken),  32'(e.taken));
        chk("mispredict", 32'(bus.mispredict), 32'(e.mis));
      end
    end else if (!reset) begin
      chk("mispredict_idle", 32'(bus.mispredict), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pc_valid  = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_taken = 1'b0;
    bus.pred_taken = 1'b0;
  endtask

  // Present one prediction, check its line, clock it in.
  task automatic predict(input logic [6:0] pc, input logic pred, input logic [6:0] want_line);
    bus.pc_valid   = 1'b1;
    bus.pc         = pc;
    bus.pred_taken = pred;
    #1;
    chk("line", 32'(bus.line), 32'(want_line));
    step();
    bus.pc_valid = 1'b0;
  endtask

  task automatic check_line(input logic [6:0] pc, input logic [6:0] want);
    bus.pc = pc;
    #1;
    chk("line_ghr", 32'(bus.line), 32'(want));
  endtask

  logic [6:0] lines3 [3];
  logic       preds3 [3];

  initial begin
    idle();
    bus.pc = 7'd5;
    reset  = 1'b1;
    #12;
    // Reset state
    chk("rst_upd_valid", 32'(bus.upd_valid), 32'd0);
    chk("rst_upd_line",  32'(bus.upd_line),  32'd0);
    chk("rst_full",      32'(bus.full),      32'd0);
    chk("rst_empty",     32'(bus.empty),     32'd1);
    chk("rst_line",      32'(bus.line),      32'd5);
    @(negedge clk);
    reset = 1'b0;
    step();

    // Three accepts at pc=2, preds 1,1,0: lines 2,3,1; ghr ends at 6.
    lines3 = '{7'd2, 7'd3, 7'd1};
    preds3 = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) predict(7'd2, preds3[i], lines3[i]);
    chk("fill3_full",  32'(bus.full),  32'd0);
    chk("fill3_empty", 32'(bus.empty), 32'd0);
    check_line(7'd0, 7'd6);

    // Correct resolve of head (line 2, pred 1).
    exp_q.push_back('{line: 7'd2, taken: 1'b1, mis: 1'b0});
    bus.res_valid = 1'b1; bus.res_taken = 1'b1;
    step();
    idle();
    chk("res1_empty", 32'(bus.empty), 32'd0);

    // Mispredict on line 3 (pred 1, snap 1): ghr repaired to 2.
    exp_q.push_back('{line: 7'd3, taken: 1'b0, mis: 1'b1});
    bus.res_valid = 1'b1; bus.res_taken = 1'b0;
    step();
    idle();
    chk("mis1_empty", 32'(bus.empty), 32'd1);
    check_line(7'd2, 7'd0);

    // Five accepts at pc=0, pred 1: ghr 2,5,11,23 -> full; 5th dropped.
    predict(7'd0, 1'b1, 7'd2);
    predict(7'd0, 1'b1, 7'd5);
    predict(7'd0, 1'b1, 7'd11);
    chk("fill_not_full", 32'(bus.full), 32'd0);
    predict(7'd0, 1'b1, 7'd23);
    chk("fill_full", 32'(bus.full), 32'd1);
    predict(7'd0, 1'b1, 7'd47);
    chk("drop_full", 32'(bus.full), 32'd1);
    check_line(7'd0, 7'd47);

    // Accept + correct resolve while full: accept refused, count 3.
    exp_q.push_back('{line: 7'd2, taken: 1'b1, mis: 1'b0});
    bus.pc_valid = 1'b1; bus.pc = 7'd0; bus.pred_taken = 1'b0;
    bus.res_valid = 1'b1; bus.res_taken = 1'b1;
    step();
    idle();
    chk("pushpop_full", 32'(bus.full), 32'd0);
    check_line(7'd0, 7'd47);

    // Correct resolve of line 5, count 2.
    exp_q.push_back('{line: 7'd5, taken: 1'b1, mis: 1'b0});
    bus.res_valid = 1'b1; bus.res_taken = 1'b1;
    step();
    idle();
    chk("res_line5_empty", 32'(bus.empty), 32'd0);

    // Mispredict on line 11 (snap 11) with a same-cycle accept: ghr = 22.
    exp_q.push_back('{line: 7'd11, taken: 1'b0, mis: 1'b1});
    bus.pc_valid = 1'b1; bus.pc = 7'd0; bus.pred_taken = 1'b1;
    bus.res_valid = 1'b1; bus.res_taken = 1'b0;
    step();
    idle();
    chk("flush_empty", 32'(bus.empty), 32'd1);
    check_line(7'd0, 7'd22);

    // Resolve while empty: ignored.
    bus.res_valid = 1'b1; bus.res_taken = 1'b1;
    step();
    idle();
    chk("res_empty_upd", 32'(bus.upd_valid), 32'd0);
    chk("res_empty_empty", 32'(bus.empty), 32'd1);

    // Two entries queued, one resolved, then async reset mid-cycle.
    predict(7'd0, 1'b1, 7'd22);
    predict(7'd0, 1'b1, 7'd45);
    predict(7'd0, 1'b0, 7'd91);
    exp_q.push_back('{line: 7'd22, taken: 1'b1, mis: 1'b0});
    bus.res_valid = 1'b1; bus.res_taken = 1'b1;
    step();
    idle();
    chk("pre_rst_upd", 32'(bus.upd_valid), 32'd1);
    @(negedge clk);
    #1;
    reset = 1'b1;
    bus.pc = 7'd0;
    #1;
    chk("arst_empty",     32'(bus.empty),     32'd1);
    chk("arst_full",      32'(bus.full),      32'd0);
    chk("arst_line",      32'(bus.line),      32'd0);
    chk("arst_upd_valid", 32'(bus.upd_valid), 32'd0);
    chk("arst_upd_line",  32'(bus.upd_line),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();
    step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_hist_index.md
# branch_hist_index

Speculative global-history index generator and in-order resolution queue for the 2-bit branch prediction table. Sits directly upstream of the prediction table. Hashes each branch PC with a speculative global history register (gshare) to produce the table `line`. Remembers every in-flight prediction, and when branches resolve, drives the table-update address and real outcome for the counter FSM's `p` input. On a mispredict it flushes the queue and repairs history.

## Interface
- `ADDR_W`, 7: table index width; matches the table `line` port.
- `HIST_W`, 7: global history length; must be ≤ `ADDR_W`.
- `DEPTH`, 4: number of outstanding unresolved predictions; power of two.

- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `pc_valid`  in  1  a branch is being predicted this cycle.
- `pc`  in  ADDR_W  branch PC index bits.
- `pred_taken`  in  1  table prediction for this branch (`dout[1]`).
- `line`  out  ADDR_W  table index = `pc ^ {0, ghr}`; combinational.
- `res_valid`  in  1  oldest outstanding branch resolves this cycle.
- `res_taken`  in  1  actual outcome of that branch.
- `upd_valid`  out  1  registered; table update request.
- `upd_line`  out  ADDR_W  registered; index to update.
- `upd_taken`  out  1  registered; outcome, drives FSM `p`.
- `mispredict`  out  1  registered; one-cycle pulse.
- `full`  out  1  queue holds `DEPTH` entries; upstream stalls.
- `empty`  out  1  queue holds 0 entries.

## Operation
- State:
  - speculative history `ghr` (`HIST_W` bits).
  - circular queue of `DEPTH` entries `{line, ghr_snap, pred}`.
  - head/tail pointers and a count (0..`DEPTH`).
- Index: `line = pc ^ zero_extend(ghr)`, computed every cycle regardless of `pc_valid`.
- Accept is `pc_valid && !full`, with `full` taken from the count at the start of the cycle. On accept:
  - enqueue `{line, ghr, pred_taken}` at the tail;
  - `ghr <= {ghr[HIST_W-2:0], pred_taken}`.
- `pc_valid` while `full`: prediction dropped; no enqueue, no `ghr` change. Upstream must hold the branch and retry.
- Resolve is `res_valid && !empty`. It pops the head, then on the next cycle:
  - `upd_valid=1`, `upd_line=head.line`, `upd_taken=res_taken`;
  - `mispredict = (res_taken != head.pred)`.
- `res_valid` while `empty`: ignored; `upd_valid=0`, no state change.
- Resolve, correct prediction: pop only; `ghr` is unaffected by the resolve.
- Resolve, mispredict:
  - count, head and tail all go to 0 (flush all younger entries);
  - `ghr <= {head.ghr_snap[HIST_W-2:0], res_taken}`;
  - a same-cycle accept is discarded: flush wins, and its `ghr` shift is not applied.
- Simultaneous accept and correct resolve: push and pop both occur; count unchanged. Legal even when `full`=1 at cycle start, but the accept is still refused because `full` is sampled before the pop.
- Pointers wrap modulo `DEPTH`.
- `full = (count == DEPTH)`, `empty = (count == 0)`; both derived from registered count.

## Timing
- Reset values: `ghr=0`, count=0, head=tail=0, `upd_valid=0`, `upd_line=0`, `upd_taken=0`, `mispredict=0`, `full=0`, `empty=1`. `line` equals `pc` during reset.
- `line`: zero-cycle latency from `pc` and current `ghr`. The table registers its read and its `dout` returns `pred_taken`; `pred_taken` must be valid in the same cycle as `pc_valid`.
- Update/mispredict outputs: exactly 1 cycle after the resolving edge. Each is high for exactly one cycle per resolve; back-to-back resolves give back-to-back pulses.
- History repair is visible on `line` the cycle after the mispredict resolve.
- Reset asserted mid-operation: all outputs go to reset values asynchronously; queue contents are discarded.

## Test plan
- Reset, then 3 accepts at `pc=2` with `pred_taken` 1,1,0 → `line` = 2, 3, 1 on successive cycles; then `ghr=6`, count=3, `full=0`, `empty=0`.
- From that state, `res_valid=1`, `res_taken=1` → next cycle `upd_valid=1`, `upd_line=2`, `upd_taken=1`, `mispredict=0`; count=2.
- Next, `res_taken=0` against the entry with pred 1 and snapshot `ghr=1` → `mispredict=1`, `upd_line=3`, `upd_taken=0`, `empty=1`, `ghr=2`; `pc=2` now gives `line=0`.
- With `DEPTH=4`, 5 consecutive accepts without resolves → `full=1` after the 4th; the 5th is dropped and `ghr` is unchanged. Then accept plus correct resolve in the same cycle → pop only, count=3.
- Same-cycle accept and mispredict resolve → queue empty next cycle; `ghr` equals repaired value only, with no extra shift.
- `res_valid` while empty → no `upd_valid`. Reset pulse with 2 entries queued → `empty=1`, `ghr=0`, `upd_valid=0` immediately.
